// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and forwarding controller for the decode->execute pipeline.
// Tracks DE/EM/MW shadow state, sequences multi-cycle vector ops and branch flushes.
module pipe_hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int VEC_CYCLES = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_src_a,
  input  logic [RA_W-1:0] id_src_b,
  input  logic            id_use_a,
  input  logic            id_use_b,
  input  logic [RA_W-1:0] id_dst,
  input  logic            id_wr,
  input  logic            id_is_load,
  input  logic            id_is_vec,
  input  logic            br_taken,
  output logic            stall_fd,
  output logic            flush_fd,
  output logic            bubble_de,
  output logic            de_hold,
  output logic            bubble_em,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            busy
);

  localparam int CNT_W = (VEC_CYCLES > 1) ? $clog2(VEC_CYCLES) : 1;
  localparam int DE = 0;
  localparam int EM = 1;
  localparam int MW = 2;

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] dst;
    logic            wr;
    logic            ld;
    logic            vec;
    logic [RA_W-1:0] src_a;
    logic [RA_W-1:0] src_b;
    logic            use_a;
    logic            use_b;
  } stage_t;

  typedef enum logic {RUN, VEC} state_t;

  // index 0 = DE, 1 = EM, 2 = MW
  stage_t             pipe_reg [3];
  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  stage_t             id_stage;
  logic               issue;
  logic               load_use;

  assign id_stage = '{v: 1'b1, dst: id_dst, wr: id_wr, ld: id_is_load, vec: id_is_vec,
                      src_a: id_src_a, src_b: id_src_b, use_a: id_use_a, use_b: id_use_b};

  assign load_use = pipe_reg[DE].v & pipe_reg[DE].ld & pipe_reg[DE].wr &
                    (pipe_reg[DE].dst != '0) &
                    ((id_use_a & (id_src_a == pipe_reg[DE].dst)) |
                     (id_use_b & (id_src_b == pipe_reg[DE].dst)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    issue      = 1'b0;
    stall_fd   = 1'b0;
    flush_fd   = 1'b0;
    bubble_de  = 1'b0;
    de_hold    = 1'b0;
    bubble_em  = 1'b0;
    busy       = 1'b0;
    if (rst) begin
      bubble_de = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (br_taken) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_de = 1'b1;
          end else if (id_valid) begin
            issue = 1'b1;
            if (id_is_vec && (VEC_CYCLES > 1)) begin
              state_next = VEC;
              cnt_next   = CNT_W'(VEC_CYCLES - 1);
            end
          end else begin
            bubble_de = 1'b1;
          end
        end
        VEC: begin
          // vector op holds DE; branches cannot resolve while it occupies execute
          de_hold   = 1'b1;
          bubble_em = 1'b1;
          stall_fd  = 1'b1;
          busy      = 1'b1;
          cnt_next  = cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      cnt_reg      <= '0;
      pipe_reg[DE] <= '0;
      pipe_reg[EM] <= '0;
      pipe_reg[MW] <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pipe_reg[MW] <= pipe_reg[EM];
      if (de_hold) begin
        pipe_reg[EM] <= '0;
      end else begin
        pipe_reg[EM] <= pipe_reg[DE];
        pipe_reg[DE] <= issue ? id_stage : '0;
      end
    end
  end

  logic [RA_W-1:0] op_src [2];
  logic            op_use [2];
  logic [1:0]      op_fwd [2];

  assign op_src[0] = pipe_reg[DE].src_a;
  assign op_src[1] = pipe_reg[DE].src_b;
  assign op_use[0] = pipe_reg[DE].use_a;
  assign op_use[1] = pipe_reg[DE].use_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic em_hit, mw_hit;
      // register 0 is hardwired, so a write to it never forwards
      assign em_hit = pipe_reg[EM].v & pipe_reg[EM].wr & (pipe_reg[EM].dst != '0) &
                      (pipe_reg[EM].dst == op_src[gi]);
      assign mw_hit = pipe_reg[MW].v & pipe_reg[MW].wr & (pipe_reg[MW].dst != '0) &
                      (pipe_reg[MW].dst == op_src[gi]);
      assign op_fwd[gi] = (rst | ~pipe_reg[DE].v | ~op_use[gi]) ? 2'b00 :
                          em_hit ? 2'b01 :
                          mw_hit ? 2'b10 : 2'b00;
    end
  endgenerate

  assign fwd_a_sel = op_fwd[0];
  assign fwd_b_sel = op_fwd[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one cycle per step, expected outputs
// queued when the step is driven and compared at the following falling edge.
module tb_pipe_hazard_ctrl;
  localparam int RA_W       = 5;
  localparam int VEC_CYCLES = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [RA_W-1:0] id_src_a, id_src_b, id_dst;
  logic            id_use_a, id_use_b, id_wr, id_is_load, id_is_vec;
  logic            br_taken;
  logic            stall_fd, flush_fd, bubble_de, de_hold, bubble_em, busy;
  logic [1:0]      fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(RA_W), .VEC_CYCLES(VEC_CYCLES)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_dst(id_dst), .id_wr(id_wr), .id_is_load(id_is_load), .id_is_vec(id_is_vec),
    .br_taken(br_taken), .stall_fd(stall_fd), .flush_fd(flush_fd), .bubble_de(bubble_de),
    .de_hold(de_hold), .bubble_em(bubble_em), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .busy(busy)
  );

  typedef struct packed {
    logic v; logic [4:0] dst; logic wr, ld, vec;
    logic [4:0] sa; logic ua; logic [4:0] sb; logic ub;
  } ins_t;

  typedef struct packed {
    logic stall, flush, bde, hold, bem, busy;
    logic [1:0] fa, fb;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return '{v:1'b1, dst:d, wr:1'b1, ld:1'b0, vec:1'b0, sa:a, ua:1'b1, sb:b, ub:1'b1};
  endfunction
  function automatic ins_t lw(input logic [4:0] d, input logic [4:0] a);
    return '{v:1'b1, dst:d, wr:1'b1, ld:1'b1, vec:1'b0, sa:a, ua:1'b1, sb:5'd0, ub:1'b0};
  endfunction
  function automatic ins_t vop(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return '{v:1'b1, dst:d, wr:1'b1, ld:1'b0, vec:1'b1, sa:a, ua:1'b1, sb:b, ub:1'b1};
  endfunction

  // expected-output shorthands: issuing, bubbling, waiting in a vector op, stalling, flushing
  function automatic obs_t e_iss(input logic [1:0] fa, input logic [1:0] fb);
    return '{stall:0, flush:0, bde:0, hold:0, bem:0, busy:0, fa:fa, fb:fb};
  endfunction
  function automatic obs_t e_bub(input logic [1:0] fa, input logic [1:0] fb);
    return '{stall:0, flush:0, bde:1, hold:0, bem:0, busy:0, fa:fa, fb:fb};
  endfunction
  function automatic obs_t e_vec(input logic [1:0] fa, input logic [1:0] fb);
    return '{stall:1, flush:0, bde:0, hold:1, bem:1, busy:1, fa:fa, fb:fb};
  endfunction
  function automatic obs_t e_stl(input logic [1:0] fa, input logic [1:0] fb);
    return '{stall:1, flush:0, bde:1, hold:0, bem:0, busy:0, fa:fa, fb:fb};
  endfunction
  function automatic obs_t e_fls(input logic [1:0] fa, input logic [1:0] fb);
    return '{stall:0, flush:1, bde:1, hold:0, bem:0, busy:0, fa:fa, fb:fb};
  endfunction

  // entered 1 time unit after a rising edge; leaves 1 time unit after the next one
  task automatic step(input string tag, input ins_t ins, input logic br, input logic r,
                      input obs_t e);
    obs_t  got;
    obs_t  want;
    string t;
    rst        = r;
    br_taken   = br;
    id_valid   = ins.v;
    id_dst     = ins.dst;
    id_wr      = ins.wr;
    id_is_load = ins.ld;
    id_is_vec  = ins.vec;
    id_src_a   = ins.sa;
    id_use_a   = ins.ua;
    id_src_b   = ins.sb;
    id_use_b   = ins.ub;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = '{stall:stall_fd, flush:flush_fd, bde:bubble_de, hold:de_hold, bem:bubble_em,
             busy:busy, fa:fwd_a_sel, fb:fwd_b_sel};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    vectors++;
    assert (got === want)
      else begin
        miscompares++;
        $error("FAIL %s observed(stall,flush,bde,hold,bem,busy,fa,fb)=%b expected=%b",
               t, got, want);
      end
    $display("step %-10s stall=%b flush=%b bde=%b hold=%b bem=%b busy=%b fa=%b fb=%b",
             t, got.stall, got.flush, got.bde, got.hold, got.bem, got.busy, got.fa, got.fb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; id_valid = 1'b0; id_dst = '0; id_wr = 1'b0;
    id_is_load = 1'b0; id_is_vec = 1'b0; id_src_a = '0; id_src_b = '0;
    id_use_a = 1'b0; id_use_b = 1'b0;
    @(posedge clk);
    #1;
    step("rst0",   nop(),           1'b0, 1'b1, e_bub(2'b00, 2'b00));
    step("rst1",   alu(5'd1, 5'd2, 5'd3), 1'b0, 1'b1, e_bub(2'b00, 2'b00));

    // load-use: lw r3 ; add r4 = r3 + r1
    step("lw_iss",  lw(5'd3, 5'd1),        1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("lu_stall", alu(5'd4, 5'd3, 5'd1), 1'b0, 1'b0, e_stl(2'b00, 2'b00));
    step("lu_issue", alu(5'd4, 5'd3, 5'd1), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("lu_fwdmw", nop(),                 1'b0, 1'b0, e_bub(2'b10, 2'b00));

    // back-to-back ALU: add r5 ; sub r6 = r5 - r2, then the same through r0
    step("add5",    alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("sub6",    alu(5'd6, 5'd5, 5'd2), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("fwd_em",  nop(),                 1'b0, 1'b0, e_bub(2'b01, 2'b00));
    step("add0",    alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("sub_r0",  alu(5'd6, 5'd0, 5'd2), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("fwd_r0",  nop(),                 1'b0, 1'b0, e_bub(2'b00, 2'b00));

    // vector op occupies DE for VEC_CYCLES cycles; branch ignored meanwhile
    step("vec_iss", vop(5'd8, 5'd1, 5'd2), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("vec_w1",  alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, e_vec(2'b00, 2'b00));
    step("vec_w2br", alu(5'd9, 5'd8, 5'd1), 1'b1, 1'b0, e_vec(2'b00, 2'b00));
    step("vec_w3",  alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, e_vec(2'b00, 2'b00));
    step("vec_w4",  alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, e_vec(2'b00, 2'b00));
    step("vec_done", alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("vec_fwd", nop(),                 1'b0, 1'b0, e_bub(2'b01, 2'b00));

    // taken branch beats a load-use hazard; discarded add r11 never forwards
    step("lw10",    lw(5'd10, 5'd1),          1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("br_flush", alu(5'd11, 5'd10, 5'd2), 1'b1, 1'b0, e_fls(2'b00, 2'b00));
    step("add12",   alu(5'd12, 5'd11, 5'd10), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("br_gone", nop(),                    1'b0, 1'b0, e_bub(2'b00, 2'b10));

    // r7 in both EM and MW: EM wins on both operands
    step("r7a",     alu(5'd7, 5'd1, 5'd2),  1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("r7b",     alu(5'd7, 5'd3, 5'd4),  1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("add13",   alu(5'd13, 5'd7, 5'd7), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("em_wins", vop(5'd14, 5'd7, 5'd1), 1'b0, 1'b0, e_iss(2'b01, 2'b01));

    // reset in the middle of a vector sequence (cnt 4,3,2)
    step("v2_w1",   nop(),                  1'b0, 1'b0, e_vec(2'b10, 2'b00));
    step("v2_w2",   nop(),                  1'b0, 1'b0, e_vec(2'b00, 2'b00));
    step("v2_rst",  alu(5'd15, 5'd1, 5'd2), 1'b0, 1'b1, e_bub(2'b00, 2'b00));
    step("post_rst", nop(),                 1'b0, 1'b0, e_bub(2'b00, 2'b00));
    step("add15",   alu(5'd15, 5'd1, 5'd2), 1'b0, 1'b0, e_iss(2'b00, 2'b00));
    step("add15_de", nop(),                 1'b0, 1'b0, e_bub(2'b00, 2'b00));

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain observed=%0d pending expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
